// File: rtl/fifo_burst_writer.sv
// ----------------------------------------------------------------------------
// fifo_burst_writer
// Write-side traffic source for the asynchronous FIFO. On an accepted start it
// pushes a burst of pattern words into the FIFO write port, stalling while the
// FIFO reports full and stopping early on abort.
// ----------------------------------------------------------------------------
module fifo_burst_writer #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    LEN_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 8'hB8
) (
   input  logic                  wrclk,
   input  logic                  wr_rst,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  burst_len,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [1:0]            mode,
   input  logic                  abort,
   input  logic                  full,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_WIDTH-1:0]  words_sent,
   output logic [15:0]           stall_cycles
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PUSH = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      PAT_INC   = 2'b00,
      PAT_CONST = 2'b01,
      PAT_LFSR  = 2'b10,
      PAT_DEC   = 2'b11
   } pattern_t;

   localparam logic [DATA_WIDTH-1:0] DATA_ONE  = DATA_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = '0;
   localparam logic [15:0]           STALL_MAX = 16'hFFFF;

   state_t                 state;
   pattern_t               mode_q;
   logic [LEN_WIDTH-1:0]   len_q;
   logic                   last_word;
   logic [DATA_WIDTH-1:0]  next_data;
   logic [DATA_WIDTH-1:0]  load_data;

   // Next word of the active pattern; every mode wraps modulo 2^DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] advance(input pattern_t           pat,
                                                     input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      case (pat)
         PAT_INC:   r = d + DATA_ONE;
         PAT_CONST: r = d;
         PAT_DEC:   r = d - DATA_ONE;
         default:   r = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
      endcase
      return r;
   endfunction

   // Write strobe and per-word helpers decoded from the current state.
   // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
   always_comb begin
      push      = (state == PUSH) & ~full & ~abort;
      last_word = (words_sent == (len_q - LEN_ONE));
      next_data = advance(mode_q, data_in);
      load_data = seed;
      // An all-zero LFSR state would lock up, so it is nudged to 1 at load.
      if ((pattern_t'(mode) == PAT_LFSR) && (seed == '0)) begin
         load_data = DATA_ONE;
      end
   end

   // Burst control FSM with registered status and data outputs.
   // NOTE: sequential state uses non-blocking assignments and the asynchronous reset
   // clears every register, so a mid-burst reset drops push in the same instant.
   always_ff @(posedge wrclk or negedge wr_rst) begin
      if (!wr_rst) begin
         state        <= IDLE;
         mode_q       <= PAT_INC;
         len_q        <= '0;
         data_in      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
         words_sent   <= '0;
         stall_cycles <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q        <= burst_len;
                  mode_q       <= pattern_t'(mode);
                  data_in      <= load_data;
                  words_sent   <= '0;
                  stall_cycles <= '0;
                  busy         <= 1'b1;
                  if (burst_len == LEN_ZERO) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= PUSH;
                  end
               end
            end

            PUSH: begin
               if (abort) begin
                  // Abort beats full; the count of words already written is kept.
                  state   <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (full) begin
                  // Hold data and count; only the stall counter moves.
                  if (stall_cycles != STALL_MAX) begin
                     stall_cycles <= stall_cycles + 16'd1;
                  end
               end else begin
                  words_sent <= words_sent + LEN_ONE;
                  data_in    <= next_data;
                  if (last_word) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo_burst_writer.md
Name: fifo_burst_writer

Overview:
Write-side producer for the asynchronous FIFO. It is the driver end of the FIFO's push/data_in/full handshake. On a start command it generates a burst of BURST words and pushes them into the FIFO write port, stalling whenever the FIFO reports full. It is used as a traffic source in the aFIFO testbench and as a reusable pattern generator in the write clock domain.

Parameters:
DATA_WIDTH, 8, width of data_in and seed; must match the FIFO data word (valores_t).
LEN_WIDTH, 8, width of burst_len and words_sent.
LFSR_TAPS, 8'hB8, Galois feedback mask for LFSR mode (x^8+x^6+x^5+x^4+1 at width 8).

Ports:
wrclk  input  1  write-domain clock, rising edge.
wr_rst  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled only in IDLE.
burst_len  input  LEN_WIDTH  number of words to push; sampled with start.
seed  input  DATA_WIDTH  first data word; sampled with start.
mode  input  2  pattern: 00 increment, 01 constant, 10 LFSR, 11 decrement; sampled with start.
abort  input  1  terminates the active burst.
full  input  1  FIFO full flag, already in the wrclk domain.
push  output  1  FIFO write strobe.
data_in  output  DATA_WIDTH  FIFO write data.
busy  output  1  high when state is not IDLE.
done  output  1  one-cycle pulse when a burst completes normally.
aborted  output  1  one-cycle pulse when a burst is terminated by abort.
words_sent  output  LEN_WIDTH  words accepted by the FIFO in the current or last burst.
stall_cycles  output  16  cycles spent in PUSH with full=1; saturates at 16'hFFFF.

Behaviour:
- Reset (wr_rst=0, asynchronous):
  - State goes to IDLE.
  - push=0, data_in=0, busy=0, done=0, aborted=0, words_sent=0, stall_cycles=0.
- FSM states: IDLE, PUSH, DONE.
- IDLE + start=1:
  - Latch burst_len and mode. Load data_in <= seed. Clear words_sent and stall_cycles.
  - If burst_len==0, go to DONE (no push is issued). Otherwise go to PUSH.
- start while busy=1: ignored, with no effect on the current burst.
- push is combinational: push = (state==PUSH) & ~full & ~abort. It never asserts while full=1.
- A word is written on the rising wrclk edge where push=1. On that edge:
  - words_sent increments.
  - data_in advances to the next pattern value.
  - If words_sent was burst_len-1, the state goes to DONE.
- Pattern update rules (all wrap modulo 2^DATA_WIDTH):
  - increment: data+1.
  - constant: data unchanged.
  - decrement: data-1.
  - LFSR: next = (data>>1) ^ (data[0] ? LFSR_TAPS : 0). A seed of 0 in LFSR mode is replaced by 1 at load.
- Full stall:
  - In PUSH with full=1, stay in PUSH and hold data_in and words_sent.
  - stall_cycles increments, saturating at 16'hFFFF.
  - Resume the cycle full falls; no word is lost or duplicated.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - words_sent holds its final value until the next accepted start.
- abort=1 in PUSH:
  - push is suppressed in that same cycle.
  - Next state is IDLE, with aborted=1 for one cycle. done stays 0.
  - words_sent keeps the count of words written before the abort.
- abort has no effect in IDLE or DONE. Simultaneous abort and full: abort wins.
- Latency: the first push can assert one cycle after start is sampled.
- Throughput: one word per cycle while full=0.
- Reset mid-burst: immediate return to IDLE with all outputs cleared; a partial burst is not resumed.
- Output timing: data_in, words_sent, done, aborted and busy are registered. push is the only combinational output.

Test Plan:
- Increment burst: seed=8'h10, burst_len=4, mode=00, full=0 → push high for 4 consecutive cycles with data 10,11,12,13; done pulses once the cycle after the last push; words_sent=4; busy low the cycle after done.
- Full stall: LFSR mode, seed=8'h01, burst_len=6, full forced high for 3 cycles after the 2nd word → words 01,B8,5C,2E,17,B3; push=0 while full=1; stall_cycles=3; no duplicated or skipped word.
- Zero length and wrap: burst_len=0 → done pulses the cycle after start with no push. Decrement burst with seed=8'h01, burst_len=3 → data 01,00,FF.
- Abort mid-burst: burst_len=10, abort asserted during the 5th push cycle → that push is suppressed; words_sent=4; aborted pulses once; done never asserts; a start 1 cycle later is accepted.
- Start while busy and reset: start with a different seed mid-burst is ignored and the data sequence is unchanged. wr_rst low mid-burst → push=0 asynchronously; all outputs return to 0; a new burst after reset starts from its new seed.
